// File: rtl/traffic_pkg.sv
// Shared state encoding and lamp-decode table for the two-road intersection sequencer.
package traffic_pkg;

  typedef enum logic [2:0] {
    S_RR1 = 3'd0,
    S_G1  = 3'd1,
    S_Y1  = 3'd2,
    S_RR2 = 3'd3,
    S_G2  = 3'd4,
    S_Y2  = 3'd5
  } state_t;

  typedef struct packed {
    logic g1;
    logic y1;
    logic r1;
    logic g2;
    logic y2;
    logic r2;
    logic d;
  } lamps_t;

  // Lamp set and direction bit per state; unused encodings fall back to all-red.
  function automatic lamps_t lamp_decode(input state_t s);
    lamps_t l;
    case (s)
      S_RR1:   l = '{g1: 1'b0, y1: 1'b0, r1: 1'b1, g2: 1'b0, y2: 1'b0, r2: 1'b1, d: 1'b1};
      S_G1:    l = '{g1: 1'b1, y1: 1'b0, r1: 1'b0, g2: 1'b0, y2: 1'b0, r2: 1'b1, d: 1'b1};
      S_Y1:    l = '{g1: 1'b0, y1: 1'b1, r1: 1'b0, g2: 1'b0, y2: 1'b0, r2: 1'b1, d: 1'b0};
      S_RR2:   l = '{g1: 1'b0, y1: 1'b0, r1: 1'b1, g2: 1'b0, y2: 1'b0, r2: 1'b1, d: 1'b0};
      S_G2:    l = '{g1: 1'b0, y1: 1'b0, r1: 1'b1, g2: 1'b1, y2: 1'b0, r2: 1'b0, d: 1'b0};
      S_Y2:    l = '{g1: 1'b0, y1: 1'b0, r1: 1'b1, g2: 1'b0, y2: 1'b1, r2: 1'b0, d: 1'b1};
      default: l = '{g1: 1'b0, y1: 1'b0, r1: 1'b1, g2: 1'b0, y2: 1'b0, r2: 1'b1, d: 1'b1};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Phase dwell down-counter: loads on phase entry, counts en-ticks, floors at zero.
module dwell_timer #(
  parameter int unsigned        CNT_W   = 8,
  parameter logic [CNT_W-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = en & (cnt == '0);

endmodule

// File: rtl/traffic_sequencer.sv
// Registered phase sequencer for a two-road intersection with demand-based
// green extension and a force-red emergency override.
module traffic_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_TICKS  = 8,
  parameter int unsigned YELLOW_TICKS = 3,
  parameter int unsigned ALLRED_TICKS = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       car1,
  input  logic       car2,
  input  logic       force_red,
  output logic       g1,
  output logic       y1,
  output logic       r1,
  output logic       g2,
  output logic       y2,
  output logic       r2,
  output logic       d,
  output logic [2:0] phase,
  output logic       phase_end
);

  localparam logic [CNT_W-1:0] G_LD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_LD  = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] RR_LD = CNT_W'(ALLRED_TICKS - 1);

  state_t           state, state_nx;
  lamps_t           lamps_q;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             expired;

  dwell_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(RR_LD)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .load_val(load_val),
    .expired (expired)
  );

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    load_val = RR_LD;
    case (state)
      // force_red parks all-red states by continuously reloading the clearance dwell
      S_RR1: begin
        if (force_red) begin
          load = 1'b1;
        end else if (expired) begin
          state_nx = S_G1;
          load     = 1'b1;
          load_val = G_LD;
        end
      end
      S_G1: begin
        if (force_red) begin
          state_nx = S_Y1;
          load     = 1'b1;
          load_val = Y_LD;
        end else if (expired) begin
          load = 1'b1;
          if (car1 && !car2) begin
            load_val = G_LD;
          end else begin
            state_nx = S_Y1;
            load_val = Y_LD;
          end
        end
      end
      S_Y1: begin
        if (expired) begin
          state_nx = S_RR2;
          load     = 1'b1;
        end
      end
      S_RR2: begin
        if (force_red) begin
          load = 1'b1;
        end else if (expired) begin
          state_nx = S_G2;
          load     = 1'b1;
          load_val = G_LD;
        end
      end
      S_G2: begin
        if (force_red) begin
          state_nx = S_Y2;
          load     = 1'b1;
          load_val = Y_LD;
        end else if (expired) begin
          load = 1'b1;
          if (car2 && !car1) begin
            load_val = G_LD;
          end else begin
            state_nx = S_Y2;
            load_val = Y_LD;
          end
        end
      end
      S_Y2: begin
        if (expired) begin
          state_nx = S_RR1;
          load     = 1'b1;
        end
      end
      default: begin
        state_nx = S_RR1;
        load     = 1'b1;
      end
    endcase
  end

  // Lamps are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RR1;
      lamps_q   <= lamp_decode(S_RR1);
      phase_end <= 1'b0;
    end else begin
      state     <= state_nx;
      lamps_q   <= lamp_decode(state_nx);
      phase_end <= (state_nx != state);
    end
  end

  assign g1    = lamps_q.g1;
  assign y1    = lamps_q.y1;
  assign r1    = lamps_q.r1;
  assign g2    = lamps_q.g2;
  assign y2    = lamps_q.y2;
  assign r2    = lamps_q.r2;
  assign d     = lamps_q.d;
  assign phase = state;

endmodule
